// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory slave for the core's memory stage.
// One request at a time over req/busy/rvalid, WAIT_CYCLES wait states, then a
// single-cycle response. Byte/half/word stores with lane masking, RV32I loads
// with sign/zero extension, err on illegal size, out-of-range address or
// misalignment.
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned H/HU/W accesses fault (err=1, no write, rdata=0)
//   undefined -> offending low address bits are forced to zero, access completes
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready, busy=0; a req is latched here
// S_WAIT | wait states counting down; busy=1
// S_RESP | rvalid=1 for one cycle with registered rdata/err; busy=1
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           we_q;
    logic [2:0]     size_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           op_we;
    logic [2:0]     op_size;
    logic [31:0]    op_addr;
    logic [31:0]    op_wdata;
    logic [29:0]    op_idx;
    logic [1:0]     lane;
    logic [3:0]     be;
    logic [31:0]    wd_lane;
    logic [31:0]    word_rd;
    logic [31:0]    word_sh;
    logic [31:0]    ld_val;
    logic           fault;
    logic           misalign;
    logic           commit;

    // State register; reset has priority over every transition.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt_q <= CW'(1)) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; rdata/err are only meaningful with rvalid, so they read 0 otherwise.
    always_comb begin
        busy   = (state_q != S_IDLE);
        rvalid = (state_q == S_RESP);
        rdata  = rvalid ? rdata_q : 32'h0;
        err    = rvalid ? err_q : 1'b0;
    end

    // Wait-state down-counter, loaded on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == S_IDLE && req) begin
            cnt_q <= CW'(WAIT_CYCLES);
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Request fields captured at accept so core-side changes during busy are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (state_q == S_IDLE && req) begin
            we_q    <= we;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Operand select: with zero wait states the commit edge is the accept edge,
    // so the live inputs are used while still in IDLE.
    always_comb begin
        op_we    = we_q;
        op_size  = size_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            op_we    = we;
            op_size  = size;
            op_addr  = addr;
            op_wdata = wdata;
        end
    end

    // Fault decode, lane selection, store byte enables and load extraction.
    always_comb begin
        op_idx = op_addr[31:2] - BASE_ADDR[31:2];

`ifdef DMEM_ALIGN_CHECK_EN
        misalign = ((op_size[1:0] == 2'd1) && op_addr[0]) ||
                   ((op_size == 3'd2) && (op_addr[1:0] != 2'b00));
        lane     = op_addr[1:0];
`else
        misalign = 1'b0;
        case (op_size[1:0])
            2'd0:    lane = op_addr[1:0];
            2'd1:    lane = {op_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
`endif

        fault = (op_size == 3'd3) || (op_size == 3'd6) || (op_size == 3'd7) ||
                (op_we && op_size[2]) ||
                (op_addr < BASE_ADDR) ||
                ({2'b00, op_idx} >= 32'(DEPTH_WORDS)) ||
                misalign;

        case (op_size[1:0])
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        wd_lane = op_wdata << {lane, 3'b000};

        word_rd = mem[op_idx[AW-1:0]];
        word_sh = word_rd >> {lane, 3'b000};
        case (op_size)
            3'd0:    ld_val = {{24{word_sh[7]}}, word_sh[7:0]};
            3'd1:    ld_val = {{16{word_sh[15]}}, word_sh[15:0]};
            3'd4:    ld_val = {24'h0, word_sh[7:0]};
            3'd5:    ld_val = {16'h0, word_sh[15:0]};
            default: ld_val = word_sh;
        endcase

        commit = (state_d == S_RESP) && (state_q != S_RESP) && !reset;
    end

    // Response registers, loaded on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (commit) begin
            err_q   <= fault;
            rdata_q <= (fault || op_we) ? 32'h0 : ld_val;
        end
    end

    // Array write on the commit edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit && op_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[op_idx[AW-1:0]][8*b +: 8] <= wd_lane[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model, one per-cycle
// compare process, directed cases with literal values, then random traffic.
module tb_data_mem_responder;

    localparam int          W     = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, rvalid, err;
    logic [31:0] rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .busy(busy), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          due;
        string       nm;
    } exp_t;
    exp_t exp_q[$];

    int   last_acc = -1000;
    int   prev_acc = -1;
    bit   spacing_chk = 1'b0;
    bit   idle_chk = 1'b0;
    logic [7:0] mem_m [0:4*DEPTH-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: byte-addressed array, sizes decoded from funct3 directly.
    function automatic void model(input bit w, input logic [2:0] sz, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] rd, output logic e);
        int nb;
        int off;
        logic [31:0] ea;
        logic [31:0] v;
        e  = 1'b0;
        rd = 32'h0;
        ea = a;
        if (sz == 3 || sz >= 6) e = 1'b1;
        if (w && (sz == 4 || sz == 5)) e = 1'b1;
        if (a < BASE) e = 1'b1;
        else if (((a - BASE) >> 2) >= DEPTH) e = 1'b1;
        nb = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        if ((a % nb) != 0) begin
            if (ALIGN) e = 1'b1;
            else ea = a - (a % nb);
        end
        if (!e) begin
            off = int'(ea - BASE);
            if (w) begin
                for (int i = 0; i < nb; i++) mem_m[off + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(mem_m[off + i]) << (8 * i));
                if (sz == 0 && v[7])  v = v | 32'hFFFF_FF00;
                if (sz == 1 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (idle_chk) begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_rvalid", 32'(rvalid), 32'd0);
                chk("idle_rdata", rdata, 32'h0);
                chk("idle_err", 32'(err), 32'd0);
            end else begin
                chk($sformatf("busy@%0d", cyc), 32'(busy),
                    32'((cyc >= last_acc) && (cyc <= last_acc + W)));
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    chk({exp_q[0].nm, "_rvalid"}, 32'(rvalid), 32'd1);
                    chk({exp_q[0].nm, "_rdata"}, rdata, exp_q[0].rd);
                    chk({exp_q[0].nm, "_err"}, 32'(err), 32'(exp_q[0].e));
                    void'(exp_q.pop_front());
                end else begin
                    chk($sformatf("no_rvalid@%0d", cyc), 32'(rvalid), 32'd0);
                end
            end
        end
    end

    // One access; abort_at >= 0 asserts reset at that many cycles after accept.
    task automatic access(input bit w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input string nm, input int abort_at,
                          output logic [31:0] mrd, output logic me);
        int n;
        n = 0;
        mrd = 32'h0;
        me = 1'b0;
        @(negedge clk); #1;
        while (busy && n < 20) begin @(negedge clk); #1; n++; end
        if (busy) begin
            total++;
            $display("FAIL %s_idle_wait: busy stuck at 1 expected 0", nm);
        end
        req = 1'b1; we = w; size = sz; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); size = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (spacing_chk && prev_acc >= 0) chk({nm, "_spacing"}, cyc - prev_acc, W + 2);
        prev_acc = cyc;
        last_acc = cyc;
        if (abort_at >= 0) begin
            repeat (abort_at + 1) @(negedge clk);
            #1;
            reset = 1'b1;
            last_acc = -1000;
            @(posedge clk); #1;
            reset = 1'b0;
            return;
        end
        model(w, sz, a, d, mrd, me);
        exp_q.push_back('{mrd, me, cyc + W, nm});
        n = 0;
        while (exp_q.size() > 0 && n < W + 10) begin @(negedge clk); #1; n++; end
        if (exp_q.size() > 0) begin
            total++;
            $display("FAIL %s_timeout: rvalid never seen, required by cycle %0d", nm, exp_q[0].due);
            exp_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        logic [2:0]  szs [5];
        int          sel;
        logic [2:0]  sz;
        logic [31:0] a;
        szs[0] = 3'd0; szs[1] = 3'd1; szs[2] = 3'd2; szs[3] = 3'd4; szs[4] = 3'd5;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle_chk = 1'b1;
        repeat (5) @(negedge clk);
        #1 idle_chk = 1'b0;

        for (int i = 0; i < 16; i++) access(1'b1, 3'd2, 32'(4 * i), $urandom, "init", -1, r, e);

        access(1'b1, 3'd2, 32'h10, 32'h8000_00F1, "sw10", -1, r, e);
        access(1'b0, 3'd2, 32'h10, 32'h0, "lw10", -1, r, e);
        chk("lit_lw10", r, 32'h8000_00F1);
        access(1'b1, 3'd0, 32'h13, 32'hABCD_EF7A, "sb13", -1, r, e);
        access(1'b0, 3'd0, 32'h13, 32'h0, "lb13", -1, r, e);
        chk("lit_lb13", r, 32'h0000_007A);
        access(1'b0, 3'd4, 32'h10, 32'h0, "lbu10", -1, r, e);
        chk("lit_lbu10", r, 32'h0000_00F1);
        access(1'b0, 3'd0, 32'h10, 32'h0, "lb10", -1, r, e);
        chk("lit_lb10", r, 32'hFFFF_FFF1);
        access(1'b0, 3'd1, 32'h12, 32'h0, "lh12", -1, r, e);
        chk("lit_lh12", r, 32'h0000_7A00);
        access(1'b0, 3'd2, 32'h10, 32'h0, "lw10b", -1, r, e);
        chk("lit_lw10b", r, 32'h7A00_00F1);

        access(1'b1, 3'd2, BASE + 32'(4 * DEPTH), 32'h1234_5678, "sw_oor", -1, r, e);
        chk("lit_sw_oor_err", 32'(e), 32'd1);
        access(1'b0, 3'd3, 32'h10, 32'h0, "ld_sz3", -1, r, e);
        chk("lit_ld_sz3_err", 32'(e), 32'd1);
        access(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, "st_sz4", -1, r, e);
        chk("lit_st_sz4_err", 32'(e), 32'd1);
        access(1'b0, 3'd2, 32'h10, 32'h0, "lw10c", -1, r, e);
        chk("lit_lw10c", r, 32'h7A00_00F1);

        access(1'b0, 3'd1, 32'h11, 32'h0, "lh11", -1, r, e);
        chk("lit_lh11_err", 32'(e), ALIGN ? 32'd1 : 32'd0);
        chk("lit_lh11", r, ALIGN ? 32'h0 : 32'h0000_00F1);

        access(1'b1, 3'd2, 32'h20, 32'h1357_2468, "sw20", -1, r, e);
        access(1'b1, 3'd2, 32'h24, 32'h2468_ACE0, "sw24", -1, r, e);
        access(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, "sw20_abort", 0, r, e);
        access(1'b1, 3'd2, 32'h24, 32'hDEAD_BEEF, "sw24_abort", W - 1, r, e);
        prev_acc = -1;
        access(1'b0, 3'd2, 32'h20, 32'h0, "lw20", -1, r, e);
        chk("lit_lw20", r, 32'h1357_2468);
        access(1'b0, 3'd2, 32'h24, 32'h0, "lw24", -1, r, e);
        chk("lit_lw24", r, 32'h2468_ACE0);

        spacing_chk = 1'b1;
        prev_acc = -1;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 99);
            sz  = szs[$urandom_range(0, 4)];
            a   = 32'($urandom_range(0, 63));
            if (sel < 5) sz = (sel < 2) ? 3'd3 : (sel < 4) ? 3'd6 : 3'd7;
            else if (sel < 10) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 1000));
            else if (sel == 10) a = 32'hFFFF_FFF0;
            access(1'($urandom), sz, a, $urandom, $sformatf("rnd%0d", i), -1, r, e);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory slave that answers the load/store requests issued by the RISC-V core's memory stage. It accepts one request at a time over a req/busy/rvalid handshake, inserts a configurable number of wait states, and performs byte/half/word stores with lane masking. It returns loads sign- or zero-extended per the RV32I funct3 size code, and flags illegal or out-of-range accesses. It replaces the zero-latency data memory so the core and its stall logic can be exercised against realistic memory latency.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; word index = addr[31:2] − BASE_ADDR[31:2].
- WAIT_CYCLES, 2: wait states between accept and response; 0 is legal.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- clk  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid; sampled only when busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- busy  out  1  request in flight; new req ignored.
- rvalid  out  1  one-cycle response strobe.
- rdata  out  32  load result, valid with rvalid; 0 for stores and errors.
- err  out  1  access fault, valid with rvalid.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: busy=0. If req=1, latch we/size/addr/wdata and load the wait counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: busy=1. Counter decrements each cycle. When it reaches 1, next state is RESP.
- Commit edge (edge entering RESP): the store writes the array and the load reads the array into rdata.
- RESP: busy=1, rvalid=1, rdata/err driven from registers. Next state is always IDLE. A req present during RESP is ignored; the core re-presents it.
- Error conditions: size ∈ {3,6,7}; store with size 4 or 5; word index ≥ DEPTH_WORDS or addr < BASE_ADDR; misalignment (see Configuration).
- On any error: err=1, rdata=0, array unchanged.
- Stores (little-endian): B writes lane addr[1:0] with wdata[7:0]; H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; W writes all four lanes. Other lanes are preserved.
- Loads: extract the byte at lane addr[1:0] or the half at lanes addr[1]*2. Sign-extend for sizes 0/1, zero-extend for 4/5. W returns the full word.
- The array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state=IDLE, busy=0, rvalid=0, rdata=0, err=0, counter=0.
- Latency: req accepted at edge N, rvalid high in cycle N+WAIT_CYCLES+1 for exactly one cycle. busy is high from N+1 through the rvalid cycle.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Reset asserted in WAIT: return to IDLE and drop the pending store (array untouched); no rvalid is produced.
- Reset asserted on the commit edge: reset wins and no write occurs.
- Reset asserted in RESP: rvalid=0 on the next cycle.
- Request fields are registered at accept, so changes on the core side during busy have no effect.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, sets err=1, performs no write and returns rdata=0.
- DMEM_ALIGN_CHECK_EN undefined: no misalignment error. The offending low address bits are forced to zero (H uses addr[1], W uses addr[1:0]=0) and the access completes normally.

## Test plan
- Reset, then idle for 5 cycles -> busy=0, rvalid=0, rdata=0, err=0 throughout.
- WAIT_CYCLES=2: SW 0x8000_00F1 @0x10, then LW @0x10 -> each rvalid exactly 3 cycles after accept; LW rdata=0x8000_00F1, err=0.
- After the above: SB 0x7A @0x13, then LB @0x13 = 0x0000_007A, LBU @0x10 = 0x0000_00F1, LB @0x10 = 0xFFFF_FFF1, LH @0x12 = 0x0000_7A00; word @0x10 reads 0x7A00_00F1.
- Out-of-range SW @(BASE_ADDR+4*DEPTH_WORDS), then size=3 load, then store with size=4 -> err=1, rdata=0 for each; a subsequent LW of any in-range word is unchanged.
- LH @0x11 -> with DMEM_ALIGN_CHECK_EN: err=1, rdata=0. Without it: returns the half at 0x10, err=0.
- SW 0xDEAD_BEEF @0x20, assert reset during WAIT, then LW @0x20 -> no rvalid for the aborted store; the load returns the old contents, not 0xDEAD_BEEF.
